spi_master_ctrl: RTL and testbench
==================================

Name: spi_master_ctrl

Overview:
- Synthesizable SPI controller (master) RTL: the initiating end of the SPI link that the slave agent BFM responds to.
- Accepts one parallel word per transfer over a valid/ready handshake and serializes it on MOSI. It generates SCLK and CS_N and deserializes MISO into a received word.
- Instantiated in hdl_top on the same SPI interface as the slave agent BFM, so the slave agent sees a real DUT driving the bus.

Parameters:
- DATA_WIDTH, 8, bits per transfer (>=2)
- CLK_DIV, 2, clk cycles per SCLK half-period (>=1)
- CPOL, 0, SCLK idle level
- CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
- MSB_FIRST, 1, 1 = MSB shifted first, 0 = LSB first

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous reset, active-low (low = reset, sampled on clk rising edge)
- tx_data  input  DATA_WIDTH  word to transmit
- tx_valid  input  1  tx_data valid
- tx_ready  output  1  controller can accept a word
- rx_data  output  DATA_WIDTH  last received word
- rx_valid  output  1  one-cycle pulse, rx_data updated
- busy  output  1  transfer in progress
- sclk  output  1  SPI serial clock
- cs_n  output  1  chip select, active-low
- mosi  output  1  serial data out
- miso  input  1  serial data in

Behaviour:
- Reset (rst low at a clk edge):
  - Next cycle: state=IDLE, sclk=CPOL, cs_n=1, mosi=0, tx_ready=0, rx_valid=0, rx_data=0, busy=0, divider and bit counters=0.
  - Reset mid-transfer aborts immediately. No rx_valid pulse; cs_n returns high the next cycle.
- FSM states: IDLE, SETUP, SHIFT, HOLD. All outputs are registered.
- IDLE:
  - tx_ready=1 (only when rst high), busy=0, cs_n=1, sclk=CPOL.
  - Accept occurs on a cycle with tx_valid & tx_ready (cycle T0).
  - On accept: latch tx_data into the shift register, go to SETUP, drop tx_ready, raise busy.
- SETUP:
  - Entered at T0+1 with cs_n=0.
  - CPHA=0: first data bit is driven on mosi at entry.
  - Lasts CLK_DIV cycles, then go to SHIFT.
- SHIFT:
  - Divider counts 0..CLK_DIV-1; at terminal count sclk toggles.
  - Exactly 2*DATA_WIDTH toggles per word. Leading edge = toggle away from CPOL.
  - CPHA=0: miso sampled on the leading edge; next bit driven on the trailing edge (none after the final trailing edge).
  - CPHA=1: bit driven on the leading edge; miso sampled on the trailing edge.
  - miso is captured in the same clk cycle that sclk toggles.
  - Received bits fill in the order set by MSB_FIRST.
  - After the final toggle, sclk=CPOL; go to HOLD.
- HOLD:
  - Lasts CLK_DIV cycles with cs_n=0 and sclk=CPOL.
  - On exit: cs_n=1, rx_data updated, rx_valid=1 for exactly one cycle, busy=0, go to IDLE.
  - tx_ready rises the cycle after HOLD exit, guaranteeing at least 1 cycle with cs_n high between words.
- Latency:
  - cs_n falls at T0+1.
  - rx_valid and cs_n rise at T0+1+CLK_DIV*(2*DATA_WIDTH+2).
  - Example: DATA_WIDTH=8, CLK_DIV=2 gives T0+37.
- Handshake rules:
  - tx_valid while tx_ready=0 is ignored; no queueing.
  - tx_data changes after accept have no effect on the current transfer.
  - rx_data holds its value until the next completed transfer.
- mosi after the last bit: holds the last bit until IDLE, then 0.

Test Plan:
- Mode 0, CLK_DIV=2, tx_data=0xA5, slave returns 0x3C:
  - mosi bits 1,0,1,0,0,1,0,1 sampled on sclk rising edges.
  - rx_data=0x3C with rx_valid pulse at T0+37.
  - 16 sclk toggles; cs_n low for 36 cycles.
- Mode 3 (CPOL=1, CPHA=1), tx_data=0x81, miso=0xFF:
  - sclk idles high; data changes on falling edge and is sampled on rising edge.
  - rx_data=0xFF; mosi sequence 1,0,0,0,0,0,0,1.
- Back-to-back with tx_valid held high, words 0x11 then 0x22:
  - Second accept occurs 1 cycle after the first rx_valid.
  - cs_n high for exactly 1 cycle between words.
  - Both words are correct on mosi.
- tx_valid asserted with tx_data=0xFF while busy:
  - Ignored; the in-flight word (0x0F) completes unchanged.
  - No extra transfer unless tx_valid is still asserted in IDLE.
- rst driven low during bit 4 of a transfer:
  - Next cycle cs_n=1, sclk=CPOL, busy=0, tx_ready=0, no rx_valid.
  - After rst high, a new 0x5A transfer completes correctly.
- CLK_DIV=1, LSB_FIRST (MSB_FIRST=0), tx_data=0x01:
  - sclk toggles every clk cycle; first mosi bit=1.
  - rx_valid at T0+19.

Source files
------------

// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_ctrl
// Purpose  : SPI master, one word per valid/ready handshake, CPOL/CPHA modes.
// Revision : 1.0
// ============================================================================
module spi_master_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 2,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  sclk,
    output logic                  cs_n,
    output logic                  mosi,
    input  logic                  miso
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TOG_W = $clog2(2 * DATA_WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [TOG_W-1:0] TOG_LAST = TOG_W'(2 * DATA_WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [TOG_W-1:0]      tog_q, tog_d;
    logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  tx_ready_q, tx_ready_d;
    logic                  busy_q, busy_d;
    logic                  sclk_q, sclk_d;
    logic                  cs_n_q, cs_n_d;
    logic                  mosi_q, mosi_d;

    logic                  w_div_done;
    logic                  w_lead;

    function automatic logic out_bit(input logic [DATA_WIDTH-1:0] w);
        return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w);
        return MSB_FIRST ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] w,
                                                       input logic b);
        return MSB_FIRST ? {w[DATA_WIDTH-2:0], b} : {b, w[DATA_WIDTH-1:1]};
    endfunction

    assign w_div_done = (div_q == DIV_LAST);
    // Even toggle index moves sclk away from its idle level.
    assign w_lead     = ~tog_q[0];

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        tog_d      = tog_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_ready_d = tx_ready_q;
        busy_d     = busy_q;
        sclk_d     = sclk_q;
        cs_n_d     = cs_n_q;
        mosi_d     = mosi_q;

        case (state_q)
            S_IDLE: begin
                tx_ready_d = 1'b1;
                busy_d     = 1'b0;
                cs_n_d     = 1'b1;
                sclk_d     = CPOL;
                mosi_d     = 1'b0;
                if (tx_valid && tx_ready_q) begin
                    tx_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    cs_n_d     = 1'b0;
                    div_d      = '0;
                    tog_d      = '0;
                    rx_sr_d    = '0;
                    state_d    = S_SETUP;
                    if (!CPHA) begin
                        mosi_d  = out_bit(tx_data);
                        tx_sr_d = shift_out(tx_data);
                    end else begin
                        tx_sr_d = tx_data;
                    end
                end
            end
            S_SETUP: begin
                div_d = div_q + 1'b1;
                if (w_div_done) begin
                    div_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                div_d = div_q + 1'b1;
                if (w_div_done) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    tog_d  = tog_q + 1'b1;
                    // Sample edge is leading for CPHA=0, trailing for CPHA=1.
                    if (w_lead ^ CPHA) begin
                        rx_sr_d = shift_in(rx_sr_q, miso);
                    end else if (tog_q != TOG_LAST) begin
                        mosi_d  = out_bit(tx_sr_q);
                        tx_sr_d = shift_out(tx_sr_q);
                    end
                    if (tog_q == TOG_LAST) begin
                        tog_d   = '0;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                div_d = div_q + 1'b1;
                if (w_div_done) begin
                    div_d      = '0;
                    cs_n_d     = 1'b1;
                    mosi_d     = 1'b0;
                    busy_d     = 1'b0;
                    rx_data_d  = rx_sr_q;
                    rx_valid_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            tog_q      <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            sclk_q     <= CPOL;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            tog_q      <= tog_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            mosi_q     <= mosi_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign sclk     = sclk_q;
    assign cs_n     = cs_n_q;
    assign mosi     = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master_ctrl
// Purpose  : Scoreboard bench for spi_master_ctrl in three modes with an SPI slave model.
// Revision : 1.0
// ============================================================================
module tb_spi_master_ctrl;

    localparam int NI = 3;
    localparam int DW = 8;
    localparam int CD_A   [NI] = '{2, 2, 1};
    localparam bit CPOL_A [NI] = '{1'b0, 1'b1, 1'b0};
    localparam bit CPHA_A [NI] = '{1'b0, 1'b1, 1'b0};
    localparam bit MSB_A  [NI] = '{1'b1, 1'b1, 1'b0};

    typedef struct {
        int         inst;
        logic [7:0] rx;
        logic [7:0] tx;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data  [NI];
    logic       tx_valid [NI];
    logic       tx_ready [NI];
    logic [7:0] rx_data  [NI];
    logic       rx_valid [NI];
    logic       busy     [NI];
    logic       sclk     [NI];
    logic       cs_n     [NI];
    logic       mosi     [NI];
    logic       miso     [NI] = '{1'b0, 1'b0, 1'b0};

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   acc_cyc;
    exp_t exp_q [$];
    logic [7:0] slv_q [$];

    // slave model state
    logic       prev_cs   [NI] = '{1'b1, 1'b1, 1'b1};
    logic       prev_sclk [NI] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] s_word    [NI];
    logic [7:0] s_got     [NI];
    int         s_tog     [NI];
    int         s_in      [NI];
    int         s_out     [NI];
    bit         lead;

    // monitor state
    int m_low    [NI] = '{0, 0, 0};
    int m_high   [NI] = '{0, 0, 0};
    int last_gap [NI] = '{0, 0, 0};
    int last_rxv [NI] = '{0, 0, 0};

    spi_master_ctrl #(.DATA_WIDTH(8), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) u_m0 (
        .clk(clk), .rst(rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
        .rx_data(rx_data[0]), .rx_valid(rx_valid[0]), .busy(busy[0]), .sclk(sclk[0]),
        .cs_n(cs_n[0]), .mosi(mosi[0]), .miso(miso[0]));

    spi_master_ctrl #(.DATA_WIDTH(8), .CLK_DIV(2), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b1)) u_m3 (
        .clk(clk), .rst(rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
        .rx_data(rx_data[1]), .rx_valid(rx_valid[1]), .busy(busy[1]), .sclk(sclk[1]),
        .cs_n(cs_n[1]), .mosi(mosi[1]), .miso(miso[1]));

    spi_master_ctrl #(.DATA_WIDTH(8), .CLK_DIV(1), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]),
        .rx_data(rx_data[2]), .rx_valid(rx_valid[2]), .busy(busy[2]), .sclk(sclk[2]),
        .cs_n(cs_n[2]), .mosi(mosi[2]), .miso(miso[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int i);
        return 1 + CD_A[i] * (2 * DW + 2);
    endfunction

    // Position of the j-th transmitted bit within the word.
    function automatic int bpos(input int j, input bit msb);
        return msb ? (DW - 1 - j) : j;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h (cyc %0d)", nm, act, want, cyc);
        end
    endtask

    task automatic fail_evt(input string nm);
        total++;
        bad++;
        $display("FAIL %s (cyc %0d)", nm, cyc);
    endtask

    // Behavioural SPI slave: shifts its word out on MISO and collects MOSI.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (prev_cs[i] && !cs_n[i]) begin
                s_word[i] = (slv_q.size() > 0) ? slv_q.pop_front() : 8'h00;
                s_tog[i]  = 0;
                s_in[i]   = 0;
                s_out[i]  = 0;
                s_got[i]  = 8'h00;
                if (!CPHA_A[i]) begin
                    miso[i]  = s_word[i][bpos(0, MSB_A[i])];
                    s_out[i] = 1;
                end
            end else if (!cs_n[i] && (sclk[i] != prev_sclk[i])) begin
                s_tog[i]++;
                lead = (sclk[i] != CPOL_A[i]);
                if (lead == !CPHA_A[i]) begin
                    if (s_in[i] < DW) s_got[i][bpos(s_in[i], MSB_A[i])] = mosi[i];
                    s_in[i]++;
                end else if (s_out[i] < DW) begin
                    miso[i] = s_word[i][bpos(s_out[i], MSB_A[i])];
                    s_out[i]++;
                end
            end
            prev_cs[i]   = cs_n[i];
            prev_sclk[i] = sclk[i];
        end
    end

    // Monitor: pops the scoreboard whenever a DUT reports a received word.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            for (int i = 0; i < NI; i++) begin
                m_low[i]  = 0;
                m_high[i] = 0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (!cs_n[i]) begin
                    m_low[i]++;
                    if (m_high[i] > 0) last_gap[i] = m_high[i];
                    m_high[i] = 0;
                end else begin
                    m_high[i]++;
                end
                if (rx_valid[i]) begin
                    if (exp_q.size() == 0) begin
                        fail_evt($sformatf("unexpected_rx_valid inst%0d", i));
                    end else begin
                        e = exp_q.pop_front();
                        chk("rx_inst", i, e.inst);
                        chk("rx_data", {24'h0, rx_data[i]}, {24'h0, e.rx});
                        chk("rx_latency", cyc, e.cyc);
                        chk("mosi_word", {24'h0, s_got[i]}, {24'h0, e.tx});
                        chk("sclk_toggles", s_tog[i], 2 * DW);
                        chk("cs_low_cycles", m_low[i], CD_A[i] * (2 * DW + 2));
                        chk("cs_n_at_done", {31'h0, cs_n[i]}, 32'h1);
                        chk("busy_at_done", {31'h0, busy[i]}, 32'h0);
                        chk("sclk_idle", {31'h0, sclk[i]}, {31'h0, CPOL_A[i]});
                        last_rxv[i] = cyc;
                    end
                    m_low[i] = 0;
                end
            end
            if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
                e = exp_q.pop_front();
                fail_evt($sformatf("rx_valid_timeout inst%0d", e.inst));
            end
        end
    end

    task automatic send(input int i, input logic [7:0] w, input logic [7:0] sw,
                        input bit hold, input logic [7:0] nxt);
        int n;
        bit ok;
        exp_t e;
        tx_data[i]  = w;
        tx_valid[i] = 1'b1;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 300) begin
            @(negedge clk);
            if (tx_ready[i]) ok = 1'b1;
            n++;
        end
        if (!ok) begin
            fail_evt("accept_timeout");
        end else begin
            e.inst = i;
            e.rx   = sw;
            e.tx   = w;
            e.cyc  = cyc + lat(i);
            exp_q.push_back(e);
            slv_q.push_back(sw);
            acc_cyc = cyc;
        end
        @(posedge clk);
        #1;
        if (hold) tx_data[i] = nxt;
        else      tx_valid[i] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() > 0) fail_evt("drain_timeout");
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int i;
        logic [7:0] w;
        logic [7:0] sw;
        rst = 1'b0;
        for (int k = 0; k < NI; k++) begin
            tx_valid[k] = 1'b0;
            tx_data[k]  = 8'h00;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("rst_tx_ready", {31'h0, tx_ready[k]}, 32'h0);
            chk("rst_cs_n", {31'h0, cs_n[k]}, 32'h1);
            chk("rst_sclk", {31'h0, sclk[k]}, {31'h0, CPOL_A[k]});
            chk("rst_busy", {31'h0, busy[k]}, 32'h0);
            chk("rst_mosi", {31'h0, mosi[k]}, 32'h0);
            chk("rst_rx_valid", {31'h0, rx_valid[k]}, 32'h0);
            chk("rst_rx_data", {24'h0, rx_data[k]}, 32'h0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("ready_not_yet", {31'h0, tx_ready[0]}, 32'h0);
        @(negedge clk);
        chk("ready_after_rst", {31'h0, tx_ready[0]}, 32'h1);
        @(posedge clk);
        #1;

        send(0, 8'hA5, 8'h3C, 1'b0, 8'h00);
        wait_idle();
        send(1, 8'h81, 8'hFF, 1'b0, 8'h00);
        wait_idle();
        send(2, 8'h01, 8'h96, 1'b0, 8'h00);
        wait_idle();

        // back-to-back with tx_valid held high
        send(0, 8'h11, 8'hE7, 1'b1, 8'h22);
        send(0, 8'h22, 8'h4B, 1'b0, 8'h00);
        chk("b2b_accept_gap", acc_cyc, last_rxv[0] + 1);
        wait_idle();
        chk("b2b_cs_high_min", {31'h0, last_gap[0] >= 1}, 32'h1);

        // new request while busy must be ignored
        send(0, 8'h0F, 8'hC3, 1'b0, 8'h00);
        repeat (5) @(posedge clk);
        #1;
        tx_data[0]  = 8'hFF;
        tx_valid[0] = 1'b1;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (tx_ready[0]) n++;
        end
        chk("ready_low_while_busy", n, 0);
        @(posedge clk);
        #1;
        tx_valid[0] = 1'b0;
        wait_idle();
        repeat (50) @(posedge clk);
        #1;

        // reset in the middle of bit 4
        send(0, 8'h96, 8'h69, 1'b0, 8'h00);
        n = 0;
        while (s_tog[0] < 7 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached_bit4", {31'h0, s_tog[0] >= 7}, 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        slv_q.delete();
        @(posedge clk);
        #1;
        chk("abort_cs_n", {31'h0, cs_n[0]}, 32'h1);
        chk("abort_sclk", {31'h0, sclk[0]}, {31'h0, CPOL_A[0]});
        chk("abort_busy", {31'h0, busy[0]}, 32'h0);
        chk("abort_tx_ready", {31'h0, tx_ready[0]}, 32'h0);
        chk("abort_rx_valid", {31'h0, rx_valid[0]}, 32'h0);
        chk("abort_rx_data", {24'h0, rx_data[0]}, 32'h0);
        rst = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        send(0, 8'h5A, 8'hD2, 1'b0, 8'h00);
        wait_idle();

        // randomized traffic across all three modes
        for (int k = 0; k < 24; k++) begin
            i  = $urandom_range(0, NI - 1);
            w  = 8'($urandom);
            sw = 8'($urandom);
            send(i, w, sw, 1'b0, 8'h00);
            wait_idle();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        repeat (20) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
